// File: rtl/shift_arb32.sv
// Two-port round-robin arbiter in front of a single shared 32-bit shifter
// (SLL/SRL/SRA/ROR) with a one-entry result register and stall counter.
module shift_arb32 #(
   parameter bit PRIO_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [31:0] a_data,
   input  logic [31:0] a_shamt,
   input  logic [1:0]  a_op,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [31:0] b_data,
   input  logic [31:0] b_shamt,
   input  logic [1:0]  b_op,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_id,
   output logic [7:0]  busy_cnt
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t      state_reg, state_next;
   logic        prio_reg, prio_next;
   logic [31:0] res_data_reg, res_data_next;
   logic        res_id_reg, res_id_next;
   logic [7:0]  busy_cnt_reg, busy_cnt_next;

   logic        can_accept, grant_a, grant_b, grant;
   logic [31:0] sh_data, sh_result;
   logic [4:0]  sh_amt;
   logic [1:0]  sh_op;
   logic [63:0] rot_wide;

   // Grant depends only on valids, FSM state and priority, never on operands.
   always_comb begin
      can_accept = !rst && ((state_reg == EMPTY) || res_ready);
      grant_a    = can_accept && a_valid && (!b_valid || !prio_reg);
      grant_b    = can_accept && b_valid && (!a_valid ||  prio_reg);
      grant      = grant_a || grant_b;
   end

   always_comb begin
      sh_data = grant_b ? b_data       : a_data;
      sh_amt  = grant_b ? b_shamt[4:0] : a_shamt[4:0];
      sh_op   = grant_b ? b_op         : a_op;
   end

   // Rotate is taken from the low half of the doubled operand shifted right.
   always_comb begin
      rot_wide  = {sh_data, sh_data} >> sh_amt;
      sh_result = sh_data;
      case (sh_op)
         2'b00:   sh_result = sh_data << sh_amt;
         2'b01:   sh_result = sh_data >> sh_amt;
         2'b10:   sh_result = $signed(sh_data) >>> sh_amt;
         default: sh_result = rot_wide[31:0];
      endcase
   end

   always_comb begin
      state_next    = state_reg;
      prio_next     = prio_reg;
      res_data_next = res_data_reg;
      res_id_next   = res_id_reg;
      busy_cnt_next = busy_cnt_reg;
      if (grant) begin
         state_next    = FULL;
         res_data_next = sh_result;
         res_id_next   = grant_b;
         prio_next     = grant_a;
      end else if ((state_reg == FULL) && res_ready) begin
         state_next = EMPTY;
      end
      if ((a_valid || b_valid) && !can_accept && (busy_cnt_reg != 8'hFF))
         busy_cnt_next = busy_cnt_reg + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= EMPTY;
         prio_reg     <= PRIO_INIT;
         res_data_reg <= 32'd0;
         res_id_reg   <= 1'b0;
         busy_cnt_reg <= 8'd0;
      end else begin
         state_reg    <= state_next;
         prio_reg     <= prio_next;
         res_data_reg <= res_data_next;
         res_id_reg   <= res_id_next;
         busy_cnt_reg <= busy_cnt_next;
      end
   end

   assign a_ready   = grant_a;
   assign b_ready   = grant_b;
   assign res_valid = (state_reg == FULL);
   assign res_data  = res_data_reg;
   assign res_id    = res_id_reg;
   assign busy_cnt  = busy_cnt_reg;

endmodule

// File: tb/tb_shift_arb32.sv
// Self-checking bench for shift_arb32: directed scenarios plus a randomized
// run scored against a queue-based reference model.
module tb_shift_arb32;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_valid, a_ready, b_valid, b_ready;
   logic [31:0] a_data, a_shamt, b_data, b_shamt;
   logic [1:0]  a_op, b_op;
   logic        res_valid, res_ready, res_id;
   logic [31:0] res_data;
   logic [7:0]  busy_cnt;

   int checks = 0;
   int errors = 0;

   shift_arb32 #(.PRIO_INIT(1'b0)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_shamt(a_shamt), .a_op(a_op),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_shamt(b_shamt), .b_op(b_op),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
      .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference shifter written from the arithmetic definition of each op.
   function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] shamt,
                                             input logic [1:0] op);
      int unsigned n;
      logic [31:0] fill;
      n = shamt & 32'd31;
      fill = d[31] ? ~(32'hFFFF_FFFF >> n) : 32'd0;
      case (op)
         2'd0:    return d << n;
         2'd1:    return d >> n;
         2'd2:    return (d >> n) | fill;
         default: return (n == 0) ? d : ((d >> n) | (d << (32 - n)));
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_valid = 0; b_valid = 0; res_ready = 0;
      a_data = 0; a_shamt = 0; a_op = 0;
      b_data = 0; b_shamt = 0; b_op = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1; a_valid = 1; b_valid = 1; res_ready = 1;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b00) begin
         errors++; $display("FAIL reset_ready: got %b want 00", {a_ready, b_ready});
      end
      tick();
      tick();
      checks++;
      if ({res_valid, res_id, res_data, busy_cnt} !== 42'd0) begin
         errors++;
         $display("FAIL reset_state: valid=%b id=%b data=%h busy=%0d want all 0",
                  res_valid, res_id, res_data, busy_cnt);
      end
      checks++;
      if ({a_ready, b_ready} !== 2'b00) begin
         errors++; $display("FAIL reset_ready_held: got %b want 00", {a_ready, b_ready});
      end
      rst = 0;
      idle_inputs();
      tick();
      $display("test_reset done");
   endtask

   task automatic test_sra();
      do_reset();
      a_valid = 1; a_data = 32'h8000_0001; a_shamt = 4; a_op = 2'b10; res_ready = 1;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b10) begin
         errors++; $display("FAIL sra_ready: got %b want 10", {a_ready, b_ready});
      end
      tick();
      a_valid = 0;
      checks++;
      if ({res_valid, res_id, res_data} !== {1'b1, 1'b0, 32'hF800_0000}) begin
         errors++; $display("FAIL sra_result: valid=%b id=%b data=%h want 1 0 f8000000",
                            res_valid, res_id, res_data);
      end
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
         errors++; $display("FAIL drain_empty: res_valid=%b want 0", res_valid);
      end
      $display("test_sra done");
   endtask

   task automatic test_ror();
      do_reset();
      b_valid = 1; b_data = 32'h0000_000F; b_shamt = 32'h24; b_op = 2'b11; res_ready = 1;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b01) begin
         errors++; $display("FAIL ror_ready: got %b want 01", {a_ready, b_ready});
      end
      tick();
      b_valid = 0;
      checks++;
      if ({res_valid, res_id, res_data} !== {1'b1, 1'b1, 32'hF000_0000}) begin
         errors++; $display("FAIL ror_result: valid=%b id=%b data=%h want 1 1 f0000000",
                            res_valid, res_id, res_data);
      end
      tick();
      $display("test_ror done");
   endtask

   task automatic test_alternation();
      do_reset();
      a_valid = 1; b_valid = 1; res_ready = 1;
      a_data = 32'h1234_5678; a_shamt = 8; a_op = 2'b00;
      b_data = 32'h1234_5678; b_shamt = 8; b_op = 2'b01;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({res_valid, res_id} !== {1'b1, 1'(k % 2)}) begin
            errors++; $display("FAIL alternate[%0d]: valid=%b id=%b want 1 %0d",
                               k, res_valid, res_id, k % 2);
         end
         checks++;
         if (res_data !== ((k % 2 == 0) ? 32'h3456_7800 : 32'h0012_3456)) begin
            errors++; $display("FAIL alternate_data[%0d]: got %h", k, res_data);
         end
      end
      idle_inputs();
      res_ready = 1;
      tick();
      $display("test_alternation done");
   endtask

   task automatic test_stall_saturation();
      int exp_busy;
      do_reset();
      a_valid = 1; a_data = 32'hCAFE_0001; a_shamt = 1; a_op = 2'b00; res_ready = 0;
      tick();
      a_data = 32'hFFFF_0000; a_shamt = 16; a_op = 2'b01;
      exp_busy = 0;
      for (int i = 0; i < 300; i++) begin
         #1;
         checks++;
         if ({a_ready, b_ready} !== 2'b00) begin
            errors++; $display("FAIL stall_ready[%0d]: got %b want 00", i, {a_ready, b_ready});
         end
         tick();
         exp_busy = (exp_busy < 255) ? exp_busy + 1 : 255;
         checks++;
         if ({res_valid, res_id, res_data, busy_cnt} !==
             {1'b1, 1'b0, 32'h95FC_0002, 8'(exp_busy)}) begin
            errors++; $display("FAIL stall_hold[%0d]: valid=%b id=%b data=%h busy=%0d want 1 0 95fc0002 %0d",
                               i, res_valid, res_id, res_data, busy_cnt, exp_busy);
         end
      end
      res_ready = 1;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b10) begin
         errors++; $display("FAIL stall_release_ready: got %b want 10", {a_ready, b_ready});
      end
      tick();
      checks++;
      if ({res_valid, res_data, busy_cnt} !== {1'b1, 32'h0000_FFFF, 8'd255}) begin
         errors++; $display("FAIL stall_release: valid=%b data=%h busy=%0d want 1 0000ffff 255",
                            res_valid, res_data, busy_cnt);
      end
      idle_inputs();
      res_ready = 1;
      tick();
      $display("test_stall_saturation done");
   endtask

   task automatic test_reset_while_full();
      do_reset();
      a_valid = 1; b_valid = 1; res_ready = 1;
      tick(); tick(); tick();        // grants A, B, A: priority now with B
      res_ready = 0;
      tick(); tick(); tick();
      checks++;
      if ({res_valid, busy_cnt} !== {1'b1, 8'd3}) begin
         errors++; $display("FAIL prefull: valid=%b busy=%0d want 1 3", res_valid, busy_cnt);
      end
      rst = 1; res_ready = 1;
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b00) begin
         errors++; $display("FAIL rst_full_ready: got %b want 00", {a_ready, b_ready});
      end
      tick();
      rst = 0;
      checks++;
      if ({res_valid, res_id, busy_cnt} !== {1'b0, 1'b0, 8'd0}) begin
         errors++; $display("FAIL rst_full_state: valid=%b id=%b busy=%0d want 0 0 0",
                            res_valid, res_id, busy_cnt);
      end
      #1;
      checks++;
      if ({a_ready, b_ready} !== 2'b10) begin
         errors++; $display("FAIL rst_full_prio: got %b want 10", {a_ready, b_ready});
      end
      idle_inputs();
      tick();
      $display("test_reset_while_full done");
   endtask

   task automatic test_random();
      logic [31:0] exp_data_q[$];
      bit          exp_id_q[$];
      bit          prio, full, can_acc, ga, gb;
      int          exp_busy, results;
      logic [31:0] tmp, exp_d;
      bit          exp_i;
      do_reset();
      prio = 0; exp_busy = 0; results = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc < 2900) begin
            a_valid = ($urandom_range(0, 9) < 6);
            b_valid = ($urandom_range(0, 9) < 6);
            res_ready = ($urandom_range(0, 3) != 0);
         end else begin
            a_valid = 0; b_valid = 0; res_ready = 1;
         end
         tmp = $urandom;
         a_data = $urandom; a_shamt = {tmp[31:5], 5'(cyc)}; a_op = 2'(cyc >> 5);
         b_data = $urandom; b_shamt = $urandom; b_op = 2'($urandom_range(0, 3));
         #1;
         full = (exp_data_q.size() != 0);
         if (res_valid && res_ready) begin
            checks++;
            if (!full) begin
               errors++; $display("FAIL rand_spurious[%0d]: unexpected result %h", cyc, res_data);
            end else begin
               exp_d = exp_data_q.pop_front();
               exp_i = exp_id_q.pop_front();
               results++;
               if ({res_id, res_data} !== {exp_i, exp_d}) begin
                  errors++; $display("FAIL rand_result[%0d]: id=%b data=%h want %b %h",
                                     cyc, res_id, res_data, exp_i, exp_d);
               end
            end
         end
         can_acc = !full || res_ready;
         ga = can_acc && a_valid && (!b_valid || !prio);
         gb = can_acc && b_valid && (!a_valid || prio);
         checks++;
         if ({a_ready, b_ready} !== {ga, gb}) begin
            errors++; $display("FAIL rand_grant[%0d]: got %b want %b", cyc, {a_ready, b_ready}, {ga, gb});
         end
         if (ga) begin
            exp_data_q.push_back(ref_shift(a_data, a_shamt, a_op)); exp_id_q.push_back(1'b0); prio = 1;
         end else if (gb) begin
            exp_data_q.push_back(ref_shift(b_data, b_shamt, b_op)); exp_id_q.push_back(1'b1); prio = 0;
         end
         if ((a_valid || b_valid) && !can_acc && exp_busy < 255) exp_busy++;
         tick();
         checks++;
         if ({res_valid, busy_cnt} !== {exp_data_q.size() != 0, 8'(exp_busy)}) begin
            errors++; $display("FAIL rand_state[%0d]: valid=%b busy=%0d want %b %0d", cyc,
                               res_valid, busy_cnt, exp_data_q.size() != 0, exp_busy);
         end
      end
      checks++;
      if (exp_data_q.size() != 0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL rand_drain: pending=%0d res_valid=%b want 0 0",
                            exp_data_q.size(), res_valid);
      end
      idle_inputs();
      $display("test_random done: %0d results scored", results);
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      test_reset();
      test_sra();
      test_ror();
      test_alternation();
      test_stall_saturation();
      test_reset_while_full();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
